ft_recovery_ctrl: RTL

- Rollback/recovery sequencer for the dual-core lockstep pair in cevero_soc.
- Consumes the fault-tolerance module's mismatch flag and the lockstep-agreed commit stream, and keeps a checkpoint PC.
- On a detected error it halts both cores, drains, drives a restore of both cores to the checkpoint PC, and resumes.
- Repeated errors without a clean stretch of commits escalate to a sticky fatal state.

---
 rtl/cevero_ft_pkg.sv | 21 ++
 rtl/ft_recovery_ctrl_if.sv | 31 +++
 rtl/ft_sat_counter.sv | 39 +++
 rtl/ft_recovery_ctrl.sv | 132 +++++++++++++
 4 files changed

// File: rtl/cevero_ft_pkg.sv
`default_nettype none
// ============================================================================
// cevero_ft_pkg : shared types and widths for the lockstep recovery sequencer
// Revision      : 1.0
// ============================================================================
package cevero_ft_pkg;

  localparam int RETRY_W  = 4;
  localparam int ERRCNT_W = 16;
  localparam int PC_W     = 32;

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    HALT    = 3'd1,
    RESTORE = 3'd2,
    RESUME  = 3'd3,
    FATAL   = 3'd4
  } ft_rec_state_t;

endpackage
`default_nettype wire

// File: rtl/ft_recovery_ctrl_if.sv
`default_nettype none
// ============================================================================
// ft_recovery_ctrl_if : FT-module / core-pair side signals of the sequencer
// Revision            : 1.0
// ============================================================================
interface ft_recovery_ctrl_if
  import cevero_ft_pkg::*;
();

  logic                error_i;
  logic                commit_i;
  logic [PC_W-1:0]     commit_pc_i;
  logic                halt_o;
  logic                restore_o;
  logic [PC_W-1:0]     restore_pc_o;
  logic                fatal_o;
  logic [RETRY_W-1:0]  retry_cnt_o;
  logic [ERRCNT_W-1:0] err_count_o;

  modport master (
    output error_i, commit_i, commit_pc_i,
    input  halt_o, restore_o, restore_pc_o, fatal_o, retry_cnt_o, err_count_o
  );

  modport slave (
    input  error_i, commit_i, commit_pc_i,
    output halt_o, restore_o, restore_pc_o, fatal_o, retry_cnt_o, err_count_o
  );

endinterface
`default_nettype wire

// File: rtl/ft_sat_counter.sv
`default_nettype none
// ============================================================================
// ft_sat_counter : up-counter with clear (priority) that sticks at all-ones
// Revision       : 1.0
// ============================================================================
module ft_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/ft_recovery_ctrl.sv
`default_nettype none
// ============================================================================
// ft_recovery_ctrl : checkpoint/rollback sequencer for the lockstep core pair
// Revision         : 1.0
// ============================================================================
module ft_recovery_ctrl
  import cevero_ft_pkg::*;
#(
  parameter logic [PC_W-1:0] BOOT_ADDR      = 32'h0000_0080,
  parameter int              DRAIN_CYCLES   = 4,
  parameter int              RESTORE_CYCLES = 8,
  parameter int              MAX_RETRY      = 3,
  parameter int              CLEAN_COMMITS  = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  ft_recovery_ctrl_if.slave  bus
);

  localparam logic [7:0]         DRAIN_LOAD   = 8'(DRAIN_CYCLES - 1);
  localparam logic [7:0]         RESTORE_LOAD = 8'(RESTORE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRY);
  localparam logic [15:0]        CLEAN_LAST   = 16'(CLEAN_COMMITS - 1);

  ft_rec_state_t      state_q, state_d;
  logic [7:0]         timer_q, timer_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [PC_W-1:0]    ckpt_q, ckpt_d;

  logic               err_inc;
  logic               clean_inc;
  logic               clean_clr;
  logic [15:0]        clean_cnt;
  logic [ERRCNT_W-1:0] err_cnt;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    retry_d   = retry_q;
    ckpt_d    = ckpt_q;
    err_inc   = 1'b0;
    clean_inc = 1'b0;
    clean_clr = 1'b0;
    case (state_q)
      RUN: begin
        // An error in the same cycle as a commit wins; that commit is not trusted.
        if (bus.error_i) begin
          if (retry_q < RETRY_MAX) begin
            state_d = HALT;
            timer_d = DRAIN_LOAD;
            retry_d = retry_q + RETRY_W'(1);
            err_inc = 1'b1;
          end else begin
            state_d = FATAL;
          end
        end else if (bus.commit_i) begin
          ckpt_d = bus.commit_pc_i;
          if (clean_cnt == CLEAN_LAST) begin
            clean_clr = 1'b1;
            retry_d   = '0;
          end else begin
            clean_inc = 1'b1;
          end
        end
      end
      HALT: begin
        if (timer_q == 8'd0) begin
          state_d = RESTORE;
          timer_d = RESTORE_LOAD;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
      RESTORE: begin
        if (timer_q == 8'd0) begin
          state_d = RESUME;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
      RESUME: begin
        state_d   = RUN;
        clean_clr = 1'b1;
      end
      FATAL: begin
        state_d = FATAL;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= RUN;
      timer_q <= '0;
      retry_q <= '0;
      ckpt_q  <= BOOT_ADDR;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      retry_q <= retry_d;
      ckpt_q  <= ckpt_d;
    end
  end

  ft_sat_counter #(.WIDTH(ERRCNT_W)) u_err_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (err_inc),
    .clr_i   (1'b0),
    .count_o (err_cnt)
  );

  ft_sat_counter #(.WIDTH(16)) u_clean_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (clean_inc),
    .clr_i   (clean_clr),
    .count_o (clean_cnt)
  );

  assign bus.halt_o       = (state_q != RUN);
  assign bus.restore_o    = (state_q == RESTORE);
  assign bus.fatal_o      = (state_q == FATAL);
  assign bus.restore_pc_o = ckpt_q;
  assign bus.retry_cnt_o  = retry_q;
  assign bus.err_count_o  = err_cnt;

endmodule
`default_nettype wire
